// File: rtl/jay_pkg.sv
// Shared definitions for the load/store unit and the register file.
//   lsu_state_t : load/store unit FSM encoding
//   DED_REG     : register-file index of the dedicated load-destination register (r2)
package jay_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2,
        ABORT  = 2'd3
    } lsu_state_t;

    localparam int DED_REG = 2;

endpackage

// File: rtl/ld_st_unit.sv
// Load/store unit placed directly upstream of the register-file write port.
// Latches a base address and store data, runs one data-memory transaction over
// a valid/ack handshake with a bounded wait, and on loads writes the returned
// byte into the dedicated register through the MemtoReg path.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               launch request, only honoured in IDLE
//   is_load, is_store   operation select, exactly one must be set
//   addr_in, wdata_in   address and store data from the register-file read ports
//   err_clr             clears the sticky timeout flag
//   mem_req, mem_we     memory request valid and write select
//   mem_addr, mem_wdata latched address and store data
//   mem_rdata, mem_ack  memory read data and one-cycle completion pulse
//   dat_in, wr_en,      register-file write data, general write enable (tied 0),
//   MemtoReg, wr_addr   dedicated-register strobe and fixed write pointer
//   busy, done, err     stall request, completion pulse, sticky timeout flag
module ld_st_unit
    import jay_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int pw      = 3,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          is_load,
    input  logic          is_store,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    input  logic          err_clr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW:0]   dat_in,
    output logic          wr_en,
    output logic          MemtoReg,
    output logic [pw:0]   wr_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    lsu_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_op_store;
    logic          r_mem_req;
    logic          r_mem_we;
    logic          r_memtoreg;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          w_launch;

    // Exactly one operation bit must accompany start for a launch to be legal.
    assign w_launch = start & (is_load ^ is_store);

    // FSM, wait counter, latches and registered outputs. Outputs are loaded
    // together with the state they belong to, so each one is a pure function
    // of the current state and the latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_op_store <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Clear first; the ABORT entry below overrides it when both coincide.
            if (err_clr) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end

            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_addr     <= addr_in;
                        r_wdata    <= wdata_in;
                        r_op_store <= is_store;
                        r_cnt      <= '0;
                        r_state    <= ACCESS;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= is_store;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ACCESS: begin
                    // Ack is checked first so an ack on the final wait cycle still completes.
                    if (mem_ack) begin
                        if (!r_op_store) begin
                            r_rdata <= mem_rdata;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                        r_state    <= WB;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_done     <= 1'b1;
                        r_memtoreg <= ~r_op_store;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state   <= ABORT;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WB, ABORT: begin
                    r_state    <= IDLE;
                    r_done     <= 1'b0;
                    r_memtoreg <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_mem_req  <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_done     <= 1'b0;
                    r_memtoreg <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign dat_in    = {1'b0, r_rdata};
    assign wr_en     = 1'b0;
    assign MemtoReg  = r_memtoreg;
    assign wr_addr   = (pw + 1)'(DED_REG);
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_ld_st_unit.sv
// Self-checking bench for ld_st_unit: scenario tasks drive operations against a
// small behavioural memory, a scoreboard queue holds the expected outcome of
// each operation and is compared against what the unit reports at done.
module tb_ld_st_unit;

    logic       clk = 1'b0;
    logic       reset, start, is_load, is_store, err_clr, mem_ack;
    logic [7:0] addr_in, wdata_in, mem_rdata;
    logic       mem_req, mem_we, wr_en, MemtoReg, busy, done, err;
    logic [7:0] mem_addr, mem_wdata;
    logic [8:0] dat_in;
    logic [3:0] wr_addr;

    ld_st_unit #(.DW(8), .AW(8), .pw(3), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
        .addr_in(addr_in), .wdata_in(wdata_in), .err_clr(err_clr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dat_in(dat_in), .wr_en(wr_en),
        .MemtoReg(MemtoReg), .wr_addr(wr_addr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         m2r;
        logic [8:0] dat;
        bit         err;
        int         done_cyc;
        int         req_cnt;
        int         bad;
    } res_t;

    res_t exp_q[$];
    res_t act_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   last_start_cyc = 0;
    int   m2r_total = 0;
    bit   err_model = 1'b0;
    bit   hold_start = 1'b0;
    logic [7:0] tb_r2 = 8'h00;

    // Cycle counter and register-file model for the dedicated register.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (MemtoReg === 1'b1) tb_r2 <= dat_in[7:0];
    end

    // One operation: pushes the expected outcome, drives the memory side and
    // records what the unit produced. ack_cyc is the ACCESS cycle (1-based)
    // in which mem_ack is returned; 0 means never.
    task automatic do_op(input bit ld, input bit st, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] rd, input int ack_cyc);
        res_t e;
        res_t o;
        bit   acked;
        bit   seen;
        acked      = (ack_cyc >= 1) && (ack_cyc <= 16);
        e.m2r      = ld && acked;
        e.dat      = {1'b0, rd};
        e.err      = acked ? err_model : 1'b1;
        e.done_cyc = acked ? ack_cyc + 1 : 17;
        e.req_cnt  = acked ? ack_cyc : 16;
        e.bad      = 0;
        exp_q.push_back(e);
        if (!acked) err_model = 1'b1;
        o.m2r = 1'b0; o.dat = 9'h000; o.err = 1'b0; o.done_cyc = -1; o.req_cnt = 0; o.bad = 0;
        seen = 1'b0;
        is_load = ld; is_store = st; addr_in = a; wdata_in = wd; start = 1'b1;
        last_start_cyc = cyc_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (mem_req === 1'b1) begin
                o.req_cnt++;
                if (mem_we !== st) o.bad++;
                if (mem_addr !== a) o.bad++;
                if (st && (mem_wdata !== wd)) o.bad++;
            end
            if (done === 1'b1) begin
                o.done_cyc = c; o.m2r = MemtoReg; o.dat = dat_in; o.err = err; seen = 1'b1;
            end
            if (MemtoReg === 1'b1) m2r_total++;
            if (seen && (busy === 1'b0)) break;
            start     = hold_start && (mem_req === 1'b1);
            mem_ack   = (c == ack_cyc);
            mem_rdata = rd;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        act_q.push_back(o);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({mem_req, mem_we, busy, done, err, MemtoReg, wr_en} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0000000", {mem_req, mem_we, busy, done, err, MemtoReg, wr_en});
        end
        checks++;
        if (wr_addr !== 4'd2) begin
            errors++; $display("FAIL reset_wr_addr got %0d exp 2", wr_addr);
        end
        checks++;
        if ({dat_in, mem_addr, mem_wdata} !== 25'h0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h exp 0", dat_in, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_zero_wait_load;
        res_t e;
        res_t o;
        do_op(1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5, 1);
        e = exp_q.pop_front(); o = act_q.pop_front();
        checks++;
        if (o.done_cyc !== e.done_cyc || o.req_cnt !== e.req_cnt || o.bad !== 0) begin
            errors++;
            $display("FAIL zw_load_timing got done@%0d req=%0d bad=%0d exp done@%0d req=%0d bad=0",
                     o.done_cyc, o.req_cnt, o.bad, e.done_cyc, e.req_cnt);
        end
        checks++;
        if (o.m2r !== e.m2r || o.dat !== e.dat) begin
            errors++; $display("FAIL zw_load_wb got m2r=%0b dat=%h exp m2r=%0b dat=%h", o.m2r, o.dat, e.m2r, e.dat);
        end
        checks++;
        if (tb_r2 !== 8'hA5) begin
            errors++; $display("FAIL zw_load_r2 got %h exp a5", tb_r2);
        end
    endtask

    task automatic test_store_wait;
        res_t e;
        res_t o;
        int   m2r_before;
        m2r_before = m2r_total;
        do_op(1'b0, 1'b1, 8'h10, 8'h7E, 8'hCC, 4);
        e = exp_q.pop_front(); o = act_q.pop_front();
        checks++;
        if (o.done_cyc !== e.done_cyc || o.req_cnt !== e.req_cnt || o.bad !== 0) begin
            errors++;
            $display("FAIL store_timing got done@%0d req=%0d bad=%0d exp done@%0d req=%0d bad=0",
                     o.done_cyc, o.req_cnt, o.bad, e.done_cyc, e.req_cnt);
        end
        checks++;
        if (m2r_total !== m2r_before || o.m2r !== e.m2r) begin
            errors++; $display("FAIL store_no_m2r got %0d strobes exp 0", m2r_total - m2r_before);
        end
        checks++;
        if (tb_r2 !== 8'hA5) begin
            errors++; $display("FAIL store_r2 got %h exp a5", tb_r2);
        end
    endtask

    task automatic test_timeout;
        res_t e;
        res_t o;
        do_op(1'b1, 1'b0, 8'h20, 8'h00, 8'h11, 0);
        e = exp_q.pop_front(); o = act_q.pop_front();
        checks++;
        if (o.done_cyc !== e.done_cyc || o.req_cnt !== e.req_cnt) begin
            errors++;
            $display("FAIL timeout_timing got done@%0d req=%0d exp done@%0d req=%0d",
                     o.done_cyc, o.req_cnt, e.done_cyc, e.req_cnt);
        end
        checks++;
        if (o.err !== e.err || o.m2r !== e.m2r) begin
            errors++; $display("FAIL timeout_abort got err=%0b m2r=%0b exp err=%0b m2r=%0b", o.err, o.m2r, e.err, e.m2r);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err !== err_model) begin
            errors++; $display("FAIL timeout_err_held got %0b exp %0b", err, err_model);
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0; err_model = 1'b0;
        checks++;
        if (err !== err_model) begin
            errors++; $display("FAIL err_clr got %0b exp %0b", err, err_model);
        end
        // Ack on the last permitted cycle completes normally.
        do_op(1'b1, 1'b0, 8'h21, 8'h00, 8'h5A, 16);
        e = exp_q.pop_front(); o = act_q.pop_front();
        checks++;
        if (o.done_cyc !== e.done_cyc || o.req_cnt !== e.req_cnt || o.err !== e.err ||
            o.m2r !== e.m2r || o.dat !== e.dat) begin
            errors++;
            $display("FAIL late_ack got done@%0d req=%0d err=%0b m2r=%0b dat=%h exp done@%0d req=%0d err=%0b m2r=%0b dat=%h",
                     o.done_cyc, o.req_cnt, o.err, o.m2r, o.dat, e.done_cyc, e.req_cnt, e.err, e.m2r, e.dat);
        end
        // Clear held through the abort: set wins on entry, clear takes effect next.
        err_clr = 1'b1;
        do_op(1'b0, 1'b1, 8'h22, 8'h33, 8'h00, 0);
        e = exp_q.pop_front(); o = act_q.pop_front();
        checks++;
        if (o.err !== e.err) begin
            errors++; $display("FAIL set_wins got %0b exp %0b", o.err, e.err);
        end
        err_clr = 1'b0; err_model = 1'b0;
        checks++;
        if (err !== err_model) begin
            errors++; $display("FAIL clr_after_abort got %0b exp %0b", err, err_model);
        end
    endtask

    task automatic test_illegal_start;
        res_t e;
        res_t o;
        int   bad;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            is_load  = (k < 2);
            is_store = (k < 2);
            start    = 1'b1;
            @(posedge clk); #1;
            if (busy !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL illegal_start got %0d busy cycles exp 0", bad);
        end
        hold_start = 1'b1;
        do_op(1'b1, 1'b0, 8'h44, 8'h00, 8'h3E, 3);
        hold_start = 1'b0;
        e = exp_q.pop_front(); o = act_q.pop_front();
        checks++;
        if (o.done_cyc !== e.done_cyc || o.req_cnt !== e.req_cnt || o.bad !== 0 || o.dat !== e.dat) begin
            errors++;
            $display("FAIL overlap_start got done@%0d req=%0d bad=%0d dat=%h exp done@%0d req=%0d bad=0 dat=%h",
                     o.done_cyc, o.req_cnt, o.bad, o.dat, e.done_cyc, e.req_cnt, e.dat);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL overlap_idle got busy=%0b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        res_t e;
        res_t o;
        int   bad;
        int   m2r_before;
        bad = 0;
        m2r_before = m2r_total;
        is_load = 1'b1; addr_in = 8'h55; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; is_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL mid_access got mem_req=%0b exp 1", mem_req);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset got req=%0b busy=%0b done=%0b exp 0/0/0", mem_req, busy, done);
        end
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (done !== 1'b0 || MemtoReg !== 1'b0 || mem_req !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0 || m2r_total !== m2r_before) begin
            errors++; $display("FAIL late_ack_ignored got %0d bad cycles exp 0", bad);
        end
        do_op(1'b1, 1'b0, 8'h66, 8'h00, 8'h9B, 2);
        e = exp_q.pop_front(); o = act_q.pop_front();
        checks++;
        if (o.done_cyc !== e.done_cyc || o.m2r !== e.m2r || o.dat !== e.dat || tb_r2 !== 8'h9B) begin
            errors++;
            $display("FAIL post_reset_load got done@%0d m2r=%0b dat=%h r2=%h exp done@%0d m2r=%0b dat=%h r2=9b",
                     o.done_cyc, o.m2r, o.dat, tb_r2, e.done_cyc, e.m2r, e.dat);
        end
    endtask

    task automatic test_back_to_back;
        res_t e;
        res_t o;
        int   first_start;
        int   m2r_before;
        int   bad;
        bad = 0;
        m2r_before = m2r_total;
        do_op(1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 1);
        first_start = last_start_cyc;
        do_op(1'b1, 1'b0, 8'h02, 8'h00, 8'h02, 1);
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front(); o = act_q.pop_front();
            if (o.done_cyc !== e.done_cyc || o.m2r !== e.m2r || o.dat !== e.dat) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL b2b_results got %0d bad ops exp 0", bad);
        end
        checks++;
        if (last_start_cyc - first_start !== 3) begin
            errors++; $display("FAIL b2b_interval got %0d exp 3", last_start_cyc - first_start);
        end
        checks++;
        if (m2r_total - m2r_before !== 2 || tb_r2 !== 8'h02) begin
            errors++; $display("FAIL b2b_r2 got %0d strobes r2=%h exp 2 strobes r2=02", m2r_total - m2r_before, tb_r2);
        end
    endtask

    // Watchdog against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; err_clr = 1'b0;
        mem_ack = 1'b0; addr_in = 8'h00; wdata_in = 8'h00; mem_rdata = 8'h00;
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_timeout();
        test_illegal_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ld_st_unit.md
Name: ld_st_unit

Overview:
- Load/store unit sitting directly upstream of the register-file write port.
- Takes a base address (register-file A read data) and store data (B read data), then runs one data-memory transaction over a valid/ack handshake with a bounded wait.
- On loads, drives the register-file write port (dat_in, MemtoReg, wr_addr) so the loaded byte lands in dedicated register r2.
- Reports busy, done and a sticky error to the control unit.

Parameters:
- DW, 8, data width of memory and registers
- AW, 8, data-memory address width
- pw, 3, register-file address pointer MSB index (wr_addr is pw+1 bits)
- TIMEOUT, 16, max cycles in ACCESS awaiting mem_ack before abort (>=2)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  launch request, sampled only in IDLE
- is_load  input  1  operation is a load
- is_store  input  1  operation is a store
- addr_in  input  AW  memory address (from datA_out)
- wdata_in  input  DW  store data (from datB_out)
- err_clr  input  1  clears sticky err
- mem_req  output  1  memory request valid
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  AW  latched address
- mem_wdata  output  DW  latched store data
- mem_rdata  input  DW  read data, valid when mem_ack=1 on a read
- mem_ack  input  1  memory completion, one-cycle pulse
- dat_in  output  DW+1  register-file write data
- wr_en  output  1  register-file general write enable, always 0 from this block
- MemtoReg  output  1  register-file dedicated-register write strobe
- wr_addr  output  pw+1  write pointer, fixed to DED_REG
- busy  output  1  operation in progress, upstream must stall
- done  output  1  one-cycle completion pulse
- err  output  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, ACCESS, WB, ABORT. Registered state; all outputs decoded from state and latched registers (Moore).
- Reset (synchronous): state=IDLE, latched addr/wdata/op/rdata=0, wait counter=0, err=0. All outputs 0 except wr_addr=DED_REG.
- IDLE:
  - busy=0.
  - start=1 with exactly one of is_load/is_store: latch addr_in, wdata_in and op; counter=0; go ACCESS.
  - start with both or neither op bit set: ignored, no state change.
- ACCESS:
  - busy=1, mem_req=1, mem_we=op_is_store; mem_addr and mem_wdata come from latches and are held stable until ack.
  - mem_ack=1: capture mem_rdata (loads); go WB.
  - Otherwise counter++. Counter==TIMEOUT-1 with no ack: go ABORT.
  - Ack arriving in the same cycle the counter hits its limit: ack wins, go WB.
- WB (one cycle):
  - busy=1, done=1.
  - MemtoReg=1 only for loads; dat_in={1'b0, rdata_q}.
  - Then go IDLE.
- ABORT (one cycle):
  - busy=1, done=1, MemtoReg=0; err set. Then go IDLE.
- err: set on entering ABORT; cleared by err_clr in any state. If set and clear occur in the same cycle, set wins.
- mem_ack outside ACCESS: ignored.
- start while busy: ignored. Upstream is responsible for holding it.
- Latency, zero-wait memory (ack in first ACCESS cycle): start at edge n, ACCESS in cycle n+1, WB in cycle n+2, r2 written at edge n+3. Each wait cycle adds 1.
- Back-to-back operation: a new start is accepted in the IDLE cycle following WB/ABORT (minimum 3-cycle issue interval).
- Reset mid-operation: return to IDLE at the edge. mem_req drops; no MemtoReg or done is issued for the abandoned operation; a late ack is ignored.
- Counter width: $clog2(TIMEOUT); no wrap possible because ACCESS exits at TIMEOUT-1.

Decomposition:
- Shared package jay_pkg: lsu_state_t enum {IDLE, ACCESS, WB, ABORT}; localparam DED_REG=2 (also used by reg_file's MemtoReg path).
- No sub-module; FSM, counter and latches fit in one module (~150 lines).

Test Plan:
- Zero-wait load: start, is_load, addr_in=8'h3C, mem_rdata=8'hA5 with ack in first ACCESS cycle -> mem_req high 1 cycle with mem_we=0 and mem_addr=8'h3C; WB cycle has MemtoReg=1, dat_in=9'h0A5, wr_addr=2, done=1; r2=8'hA5 three edges after start.
- Store with 3 wait cycles: addr_in=8'h10, wdata_in=8'h7E, ack on 4th ACCESS cycle -> mem_req high 4 cycles with mem_we=1 and mem_wdata=8'h7E stable; done 1 cycle; MemtoReg never asserted.
- Timeout: load, no ack -> mem_req high exactly 16 cycles, then ABORT with done=1 and err=1 held. Ack in cycle 16 instead -> WB and err stays 0. err_clr pulse -> err=0.
- Illegal and overlapping starts: start with is_load=is_store=1 -> stays IDLE, busy=0. start during ACCESS -> ignored, only one mem_req burst.
- Reset mid-ACCESS after 2 wait cycles, then ack 1 cycle later -> mem_req=0 after the reset edge; no done or MemtoReg; next load completes normally.
- Back-to-back loads 8'h01 then 8'h02, zero-wait -> second start accepted in the cycle after first WB; two MemtoReg pulses; r2 ends at 8'h02.
